// File: rtl/change_dispenser.sv
// change_dispenser: queues vend/change jobs and drives a one-item-at-a-time ejector handshake with hopper tracking
module change_dispenser #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend,
  input  logic [1:0]       change,
  input  logic             fill_5,
  input  logic             fill_10,
  input  logic             eject_ack,
  output logic             eject_req,
  output logic [1:0]       eject_sel,
  output logic             busy,
  output logic             full,
  output logic             fault,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, PLAN, REQ, FAULT} state_t;
  state_t           state_q;
  logic [2:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q, count_d;
  logic             prod_due_q, req_q, fault_q;
  logic [1:0]       owed_q, sel_q;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] cnt5_q, cnt5_d, cnt10_q, cnt10_d;
  logic             evt, pop, push, drop, take, dec5, dec10;
  assign evt   = vend | (|change);
  assign pop   = (state_q == IDLE) && (count_q != '0);
  assign full  = count_q == (AW+1)'(DEPTH);
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;
  assign take  = (state_q == REQ) && eject_ack;
  assign dec5  = take && (sel_q == 2'b01);
  assign dec10 = take && (sel_q == 2'b10);
  assign busy  = (state_q != IDLE) || (count_q != '0);
  assign eject_req = req_q;
  assign eject_sel = sel_q;
  assign fault     = fault_q;
  assign cnt_5     = cnt5_q;
  assign cnt_10    = cnt10_q;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // a fill and an eject on the same hopper cancel; fills saturate
  always_comb begin
    cnt5_d  = (fill_5 && !dec5) ? ((&cnt5_q) ? cnt5_q : cnt5_q + 1'b1)
            : (dec5 && !fill_5) ? cnt5_q - 1'b1 : cnt5_q;
    cnt10_d = (fill_10 && !dec10) ? ((&cnt10_q) ? cnt10_q : cnt10_q + 1'b1)
            : (dec10 && !fill_10) ? cnt10_q - 1'b1 : cnt10_q;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {vend, change};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cnt5_q  <= '0;
      cnt10_q <= '0;
    end else begin
      wr_q    <= push ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      count_q <= count_d;
      cnt5_q  <= cnt5_d;
      cnt10_q <= cnt10_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prod_due_q <= 1'b0;
      owed_q     <= '0;
      timer_q    <= '0;
      req_q      <= 1'b0;
      sel_q      <= 2'b00;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          {prod_due_q, owed_q} <= mem_q[rd_q];
          state_q <= PLAN;
        end
        PLAN: begin
          timer_q <= '0;
          if (prod_due_q) begin
            sel_q   <= 2'b00;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else if (owed_q >= 2'd2 && cnt10_q != '0) begin
            sel_q   <= 2'b10;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else if (owed_q != 2'd0 && cnt5_q != '0) begin
            sel_q   <= 2'b01;
            req_q   <= 1'b1;
            state_q <= REQ;
          end else if (owed_q == 2'd0) begin
            state_q <= IDLE;
          end else begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end
        end
        REQ: if (eject_ack) begin
          // sel encodes the coin value in 5-units, so it doubles as the amount paid
          prod_due_q <= 1'b0;
          owed_q     <= owed_q - sel_q;
          req_q      <= 1'b0;
          state_q    <= PLAN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          req_q   <= 1'b0;
          fault_q <= 1'b1;
          state_q <= FAULT;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
        default: req_q <= 1'b0;
      endcase
      if (drop) fault_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: cycle-level vector table plus overflow, timeout and async-reset sequences
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vend = 1'b0, fill_5 = 1'b0, fill_10 = 1'b0, eject_ack = 1'b0;
  logic [1:0] change = 2'b00;
  logic       eject_req, busy, full, fault;
  logic [1:0] eject_sel;
  logic [7:0] cnt_5, cnt_10;
  int checks = 0, errors = 0;

  change_dispenser dut (
    .clk(clk), .rst(rst), .vend(vend), .change(change), .fill_5(fill_5),
    .fill_10(fill_10), .eject_ack(eject_ack), .eject_req(eject_req),
    .eject_sel(eject_sel), .busy(busy), .full(full), .fault(fault),
    .cnt_5(cnt_5), .cnt_10(cnt_10)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, vend; logic [1:0] change; logic f5, f10, ack;
    logic req; logic [1:0] sel; logic busy, full, fault; logic [7:0] c5, c10;
  } vec_t;

  function automatic vec_t v(int r, int vd, int ch, int f5, int f10, int ak,
                             int rq, int sl, int bz, int fl, int ft, int c5, int c10);
    vec_t t;
    t.rst = r[0]; t.vend = vd[0]; t.change = ch[1:0]; t.f5 = f5[0]; t.f10 = f10[0];
    t.ack = ak[0]; t.req = rq[0]; t.sel = sl[1:0]; t.busy = bz[0]; t.full = fl[0];
    t.fault = ft[0]; t.c5 = c5[7:0]; t.c10 = c10[7:0];
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!eject_req && n < max) begin
      tick();
      n++;
    end
    chk("wait_req", 32'(eject_req), 32'd1);
  endtask

  vec_t tbl [39];

  initial begin
    //            r vd ch f5 f10 ak | rq sl bz fl ft c5 c10
    tbl[0]  = v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = v(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2, 0);
    tbl[3]  = v(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 3, 0);
    tbl[4]  = v(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 3, 1);
    tbl[5]  = v(1, 1, 2, 0, 0, 0,   0, 0, 1, 0, 0, 3, 1);
    tbl[6]  = v(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 3, 1);
    tbl[7]  = v(1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 3, 1);
    tbl[8]  = v(1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 3, 1);
    tbl[9]  = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 1);
    tbl[10] = v(1, 0, 0, 0, 0, 1,   1, 2, 1, 0, 0, 3, 1);
    tbl[11] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 0);
    tbl[12] = v(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 3, 0);
    tbl[13] = v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[14] = v(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    tbl[15] = v(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2, 0);
    tbl[16] = v(1, 0, 2, 0, 0, 0,   0, 0, 1, 0, 0, 2, 0);
    tbl[17] = v(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 2, 0);
    tbl[18] = v(1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 2, 0);
    tbl[19] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 0);
    tbl[20] = v(1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 1, 0);
    tbl[21] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0);
    tbl[22] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[23] = v(1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    tbl[24] = v(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    tbl[25] = v(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 0);
    tbl[26] = v(1, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 1, 0);
    tbl[27] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 1, 0);
    tbl[28] = v(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[29] = v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 1, 1);
    tbl[30] = v(1, 1, 3, 0, 0, 0,   0, 0, 1, 0, 0, 1, 1);
    tbl[31] = v(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 1);
    tbl[32] = v(1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 1);
    tbl[33] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 1);
    tbl[34] = v(1, 0, 0, 0, 0, 0,   1, 2, 1, 0, 0, 1, 1);
    tbl[35] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 0);
    tbl[36] = v(1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 1, 0);
    tbl[37] = v(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0);
    tbl[38] = v(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);

    #1;
    for (int i = 0; i < 39; i++) begin
      rst = tbl[i].rst; vend = tbl[i].vend; change = tbl[i].change;
      fill_5 = tbl[i].f5; fill_10 = tbl[i].f10; eject_ack = tbl[i].ack;
      tick();
      chk($sformatf("row%0d req", i), 32'(eject_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("row%0d sel", i), 32'(eject_sel), 32'(tbl[i].sel));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d full", i), 32'(full), 32'(tbl[i].full));
      chk($sformatf("row%0d fault", i), 32'(fault), 32'(tbl[i].fault));
      chk($sformatf("row%0d cnt_5", i), 32'(cnt_5), 32'(tbl[i].c5));
      chk($sformatf("row%0d cnt_10", i), 32'(cnt_10), 32'(tbl[i].c10));
    end
    vend = 0; change = 0; fill_5 = 0; fill_10 = 0; eject_ack = 0;

    // FIFO overflow while the ejector is stalled, then async reset mid-handshake
    rst = 0; tick(); rst = 1;
    vend = 1; tick(); vend = 0;
    wait_req(10);
    for (int j = 1; j <= 5; j++) begin
      vend = 1;
      tick();
      chk($sformatf("ovf%0d full", j), 32'(full), 32'(j >= 4));
      chk($sformatf("ovf%0d fault", j), 32'(fault), 32'(j == 5));
    end
    vend = 0;
    chk("ovf req held", 32'(eject_req), 32'd1);
    #2 rst = 0;
    #1;
    chk("arst req", 32'(eject_req), 32'd0);
    chk("arst full", 32'(full), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst fault", 32'(fault), 32'd0);
    tick(); rst = 1;

    // ack timeout
    vend = 1; tick(); vend = 0;
    wait_req(10);
    begin
      int n = 0, high = 0;
      while (!fault && n < 30) begin
        tick();
        n++;
        if (eject_req) high++;
      end
      chk("tmo cycles", 32'(n), 32'd15);
      chk("tmo req high", 32'(high), 32'd14);
    end
    chk("tmo fault", 32'(fault), 32'd1);
    chk("tmo req", 32'(eject_req), 32'd0);
    chk("tmo busy", 32'(busy), 32'd1);
    #2 rst = 0;
    #1;
    chk("arst2 fault", 32'(fault), 32'd0);
    chk("arst2 busy", 32'(busy), 32'd0);
    chk("arst2 req", 32'(eject_req), 32'd0);
    chk("arst2 sel", 32'(eject_sel), 32'd0);
    chk("arst2 cnt", 32'({cnt_5, cnt_10}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side companion to the vending machine FSM.
- Consumes the machine's product pulse (`vend`) and change code (`change`), queues the resulting payout jobs, and drives a mechanical ejector one item at a time over a req/ack handshake.
- Tracks coin counts in a 5-unit hopper and a 10-unit hopper, and substitutes two 5-coins when the 10-hopper is empty.
- Sits between the vending machine core and the product/coin ejector hardware.

Parameters:
DEPTH  4  job FIFO entries; power of 2, at least 2
CNT_W  8  hopper counter width
TIMEOUT  15  maximum cycles in REQ waiting for eject_ack before fault

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset; block is in reset while rst=0
vend  input  1  one-cycle pulse: product owed
change  input  2  change owed, in 5-unit coins: 00=0, 01=5, 10=10, 11=15
fill_5  input  1  pulse: one 5-coin added to hopper
fill_10  input  1  pulse: one 10-coin added to hopper
eject_ack  input  1  ejector completed current item
eject_req  output  1  ejector request, held until ack
eject_sel  output  2  item to eject: 00=product, 01=5-coin, 10=10-coin
busy  output  1  FSM not in IDLE, or FIFO non-empty
full  output  1  FIFO holds DEPTH jobs
fault  output  1  sticky error flag, cleared only by reset
cnt_5  output  CNT_W  5-coins in hopper
cnt_10  output  CNT_W  10-coins in hopper

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, state=IDLE. eject_req=0, eject_sel=00, fault=0, full=0, busy=0, cnt_5=0, cnt_10=0.
- Job capture:
  - A cycle is an event if vend=1 or change!=00.
  - An event pushes {vend, change} at the clock edge.
  - If the FIFO is full, the job is dropped and fault is set. Exception: if a pop happens in the same cycle, the push is accepted.
- FSM states: IDLE, PLAN, REQ, FAULT. Working registers: prod_due (1 bit), owed (2 bits, in 5-units).
- IDLE: if the FIFO is non-empty, pop it into prod_due/owed and go to PLAN.
- PLAN: choose the next item in this priority order:
  - prod_due=1 -> sel=00.
  - Else owed>=2 and cnt_10>0 -> sel=10.
  - Else owed>=1 and cnt_5>0 -> sel=01.
  - Else owed=0 -> IDLE.
  - Else (coins owed, no usable coin) -> FAULT.
  - Any item chosen -> REQ.
- REQ:
  - eject_req=1 and eject_sel stay stable until eject_ack=1 is sampled.
  - On ack:
    - Clear prod_due, or subtract the coin from owed (10-coin: owed-2; 5-coin: owed-1).
    - Decrement the matching hopper count.
    - eject_req=0 from the next cycle; go to PLAN.
  - Ack timer resets on REQ entry. If TIMEOUT cycles pass without ack -> FAULT.
- eject_ack is ignored outside REQ.
- FAULT:
  - fault=1, eject_req=0; stays here until reset.
  - FIFO still accepts pushes until full; no further pops.
- Latency: event captured at edge k -> IDLE pops at k+1 -> eject_req high after edge k+2 (FSM idle, FIFO empty beforehand).
- Each eject_req rise is one PLAN cycle after the previous ack.
- Hopper counters:
  - Fill and decrement on the same hopper in the same cycle: net unchanged.
  - Fill saturates at 2^CNT_W-1.
  - Decrement only happens after a successful PLAN check, so it never underflows.
- FIFO pointers wrap modulo DEPTH. full and busy are combinational from registered state.
- Reset mid-handshake drops eject_req immediately (asynchronously) and discards all queued jobs.

Test Plan:
- Reset, fill_5 x3, fill_10 x1, event vend=1 change=10 -> eject_sel 00 then 10 (two handshakes); cnt_10=0, cnt_5=3; busy drops after last ack.
- cnt_10=0, cnt_5=2, event vend=0 change=10 -> two consecutive eject_sel=01 requests; cnt_5=0; fault=0.
- cnt_5=0, cnt_10=0, event change=01 -> fault=1 two cycles after capture; eject_req never rises; later fill_5 does not clear fault.
- Ejector held off (ack=0), DEPTH+1 events -> full=1 after 4 captures; 5th dropped; fault=1.
- Hold ack low for TIMEOUT cycles in REQ -> fault=1, eject_req=0; then assert rst=0 mid-cycle -> all outputs at reset values immediately.
- Ack at the first REQ cycle with vend=1, change=11, cnt_10=1, cnt_5=1 -> sequence 00, 10, 01; both hoppers at 0; back to IDLE.
